// File: rtl/mem_ctrl_arb.sv
// -----------------------------------------------------------------------------
// mem_ctrl_arb
//   Round-robin arbiter and byte-serial memory sequencer for NCH requesters.
//   Channel 0 is instruction fetch.
//   Only one access is in flight at a time. Each access moves one byte per cycle
//   over an 8-bit memory port. Reads return zero-extended little-endian data.
//
// Parameters
//   NCH  number of requester channels (2..4)
//   AW   per-channel address width
//
// Ports
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_rdy              global ready; low freezes all state
//   i_req/i_we         per-channel request / write select
//   i_addr/i_nbytes    per-channel byte address / size (1, 2, else 4), flattened
//   i_wdata            per-channel store data, flattened
//   i_flush            per-channel cancel of a pending or active read
//   i_io_buffer_full   UART transmit buffer full (used only with IO stall)
//   i_mem_din          memory read byte, valid one cycle after its address
//   o_mem_dout/o_mem_a/o_mem_wr   memory write byte / byte address / write strobe
//   o_rdata            assembled read data, valid while o_done is high
//   o_done             one-cycle completion pulse per channel
//   o_busy             high whenever the sequencer is not idle
//
// Configuration macro
//   MEM_CTRL_IO_STALL_EN  When defined, a write byte whose address has bits
//                         [17:16]==2'b11 waits while i_io_buffer_full is high.
// -----------------------------------------------------------------------------
module mem_ctrl_arb #(
    parameter int NCH = 2,
    parameter int AW  = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rdy,
    input  logic [NCH-1:0]    i_req,
    input  logic [NCH-1:0]    i_we,
    input  logic [NCH*AW-1:0] i_addr,
    input  logic [NCH*3-1:0]  i_nbytes,
    input  logic [NCH*32-1:0] i_wdata,
    input  logic [NCH-1:0]    i_flush,
    input  logic              i_io_buffer_full,
    input  logic [7:0]        i_mem_din,
    output logic [7:0]        o_mem_dout,
    output logic [31:0]       o_mem_a,
    output logic              o_mem_wr,
    output logic [31:0]       o_rdata,
    output logic [NCH-1:0]    o_done,
    output logic              o_busy
);

    localparam int CW = (NCH > 2) ? 2 : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_READ   = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    logic [1:0]     r_state;
    logic [CW-1:0]  r_ch;
    logic [CW-1:0]  r_last;
    logic [31:0]    r_base;
    logic [2:0]     r_n;
    logic [31:0]    r_wdata;
    logic [2:0]     r_cnt;
    logic [31:0]    r_rbuf;
    logic [31:0]    r_rdata;
    logic [31:0]    r_mem_a;
    logic [7:0]     r_mem_dout;
    logic           r_wr_en;
    logic [NCH-1:0] r_done;

    logic [NCH-1:0] w_elig;
    logic           w_gnt_vld;
    logic [CW-1:0]  w_gnt_ch;
    logic [2:0]     w_g_nb;
    logic [2:0]     w_g_n;
    logic [31:0]    w_g_base;
    logic [31:0]    w_g_wdata;
    logic [2:0]     w_cnt_inc;
    logic [1:0]     w_cap_idx;
    logic [31:0]    w_rbuf_nxt;
    logic [31:0]    w_nxt_a;
    logic           w_stall;

    assign w_elig    = i_req & ~i_flush;
    assign w_cnt_inc = r_cnt + 3'd1;
    // r_cnt counts READ cycles; the byte captured in cycle c was addressed in cycle c-1.
    assign w_cap_idx = 2'(r_cnt - 3'd1);
    assign w_nxt_a   = r_base + 32'(w_cnt_inc);

`ifdef MEM_CTRL_IO_STALL_EN
    assign w_stall = (r_state == S_WRITE) && (r_mem_a[17:16] == 2'b11) && i_io_buffer_full;
`else
    assign w_stall = i_io_buffer_full & 1'b0;
`endif

    // Round-robin search starting one past the last granted channel
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_ch  = '0;
        for (int i = 1; i <= NCH; i++) begin
            if (!w_gnt_vld && w_elig[(int'(r_last) + i) % NCH]) begin
                w_gnt_vld = 1'b1;
                w_gnt_ch  = CW'((int'(r_last) + i) % NCH);
            end else begin
                w_gnt_vld = w_gnt_vld;
            end
        end
    end

    // Select the winning channel's request fields and decode its size
    always_comb begin
        w_g_base  = 32'(i_addr[w_gnt_ch*AW +: AW]);
        w_g_wdata = i_wdata[w_gnt_ch*32 +: 32];
        w_g_nb    = i_nbytes[w_gnt_ch*3 +: 3];
        case (w_g_nb)
            3'd1:    w_g_n = 3'd1;
            3'd2:    w_g_n = 3'd2;
            default: w_g_n = 3'd4;
        endcase
    end

    // Insert the incoming memory byte into the read assembly buffer
    always_comb begin
        w_rbuf_nxt = r_rbuf;
        w_rbuf_nxt[8*w_cap_idx +: 8] = i_mem_din;
    end

    // Sequencer state, request latch and memory-port registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_ch       <= '0;
            r_last     <= CW'(NCH - 1);
            r_base     <= 32'd0;
            r_n        <= 3'd0;
            r_wdata    <= 32'd0;
            r_cnt      <= 3'd0;
            r_rbuf     <= 32'd0;
            r_rdata    <= 32'd0;
            r_mem_a    <= 32'd0;
            r_mem_dout <= 8'd0;
            r_wr_en    <= 1'b0;
            r_done     <= '0;
        end else if (i_rdy) begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_vld) begin
                        r_ch       <= w_gnt_ch;
                        r_last     <= w_gnt_ch;
                        r_base     <= w_g_base;
                        r_n        <= w_g_n;
                        r_wdata    <= w_g_wdata;
                        r_cnt      <= 3'd0;
                        r_rbuf     <= 32'd0;
                        r_mem_a    <= w_g_base;
                        r_mem_dout <= w_g_wdata[7:0];
                        if (i_we[w_gnt_ch]) begin
                            r_state <= S_WRITE;
                            r_wr_en <= 1'b1;
                        end else begin
                            r_state <= S_READ;
                            r_wr_en <= 1'b0;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_READ: begin
                    if (i_flush[r_ch]) begin
                        // Abandon the read; the result register keeps its old value.
                        r_state <= S_IDLE;
                    end else begin
                        if (r_cnt != 3'd0) begin
                            r_rbuf <= w_rbuf_nxt;
                        end else begin
                            r_rbuf <= r_rbuf;
                        end
                        if (r_cnt == r_n) begin
                            r_state      <= S_FINISH;
                            r_rdata      <= w_rbuf_nxt;
                            r_done[r_ch] <= 1'b1;
                        end else begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc < r_n) begin
                                r_mem_a <= w_nxt_a;
                            end else begin
                                r_mem_a <= r_mem_a;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    if (w_stall) begin
                        // Hold the same byte and address until the IO buffer drains.
                        r_cnt <= r_cnt;
                    end else if (r_cnt == (r_n - 3'd1)) begin
                        r_state      <= S_FINISH;
                        r_wr_en      <= 1'b0;
                        r_done[r_ch] <= 1'b1;
                    end else begin
                        r_cnt      <= w_cnt_inc;
                        r_mem_a    <= w_nxt_a;
                        r_mem_dout <= r_wdata[8*w_cnt_inc[1:0] +: 8];
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                    r_done  <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_wr_en <= 1'b0;
                    r_done  <= '0;
                end
            endcase
        end else begin
            r_state <= r_state;
        end
    end

    assign o_mem_a    = r_mem_a;
    assign o_mem_dout = r_mem_dout;
    // The strobe is qualified combinationally so that a dropped ready or an IO stall
    // suppresses the write in the same cycle.
    assign o_mem_wr   = r_wr_en & i_rdy & ~w_stall;
    assign o_rdata    = r_rdata;
    assign o_done     = r_done;
    assign o_busy     = (r_state != S_IDLE);

endmodule

// File: doc/mem_ctrl_arb.md
MEM_CTRL_ARB -- requirements
Module: mem_ctrl_arb

Interface
REQ-001 Parameter NCH, default 2, number of requester channels (2..4); channel 0 is instruction fetch.
REQ-002 Parameter AW, default 32, address width per channel.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 rdy  input  1  global ready; low freezes all state.
REQ-006 req  input  NCH  per-channel access request, held high until the matching done.
REQ-007 we  input  NCH  per-channel write select (1 = store).
REQ-008 addr  input  NCH*AW  per-channel byte address, flattened, channel i at [i*AW +: AW].
REQ-009 nbytes  input  NCH*3  per-channel access size; 1, 2 or 4 bytes.
REQ-010 wdata  input  NCH*32  per-channel store data, little-endian.
REQ-011 flush  input  NCH  per-channel cancel of pending or active reads (branch mispredict).
REQ-012 io_buffer_full  input  1  UART transmit buffer full.
REQ-013 mem_din  input  8  memory read byte, valid one cycle after address.
REQ-014 mem_dout  output  8  memory write byte.
REQ-015 mem_a  output  32  memory byte address.
REQ-016 mem_wr  output  1  1 = write this cycle.
REQ-017 rdata  output  32  assembled read data, zero-extended, valid while done is high.
REQ-018 done  output  NCH  one-cycle completion pulse for the granted channel.
REQ-019 busy  output  1  high in any state other than IDLE.

Function
REQ-020 FSM states: IDLE, READ, WRITE, FINISH; exactly one access is in flight at a time.
REQ-021 In IDLE, grant is round-robin among channels with req high and flush low, searching from (last granted + 1) mod NCH; the channel, addr, nbytes, we and wdata are latched at grant.
REQ-022 nbytes values other than 1 or 2 are treated as 4.
REQ-023 READ: byte k address (base+k) is driven in cycle k+1 after grant, for k = 0..n-1; mem_din is captured one cycle later into rdata[8k+7:8k]; after the last capture the FSM enters FINISH.
REQ-024 WRITE: byte k of wdata is driven with mem_wr=1 at base+k in cycle k+1 after grant, k = 0..n-1; then FINISH.
REQ-025 FINISH lasts one cycle, pulses done for the granted channel, then returns to IDLE; a new grant is possible in that following IDLE cycle.
REQ-026 Read latency, grant to done: n+2 cycles; write latency: n+1 cycles.
REQ-027 flush high for the granted channel during READ aborts the access: no done, return to IDLE next cycle, rdata unchanged.
REQ-028 Writes are never aborted by flush.
REQ-029 mem_wr is 0 in IDLE, READ, FINISH, and whenever rdy is low.
REQ-030 rdy low: FSM, counters, latched request and outputs other than mem_wr hold their values.
REQ-031 Address arithmetic wraps modulo 2^32; no alignment check.

Reset
REQ-032 On rst high: state IDLE, round-robin pointer NCH-1 (channel 0 wins first), mem_a=0, mem_dout=0, mem_wr=0, rdata=0, done=0, busy=0.
REQ-033 rst asserted mid-access abandons it immediately; no done is issued for it.

Configuration
REQ-034 Macro MEM_CTRL_IO_STALL_EN: when defined, a WRITE byte whose address has bits [17:16]==2'b11 is held (mem_wr=0, same byte and address) while io_buffer_full is high, and issued in the first cycle it is low; when undefined, io_buffer_full is ignored and all writes proceed at one byte per cycle.

Verification
REQ-035 Reset, then ch0 read nbytes=4 at 0x100, memory bytes 0x13,0x00,0x00,0x93 -> mem_a 0x100..0x103 on cycles 1..4, done[0] at cycle 6, rdata=0x93000013.
REQ-036 ch1 write nbytes=2 wdata=0x0000BEEF at 0x200 -> mem_wr=1 with (0x200,0xEF) then (0x201,0xBE), done[1] at cycle 3, never a third write byte.
REQ-037 ch0 and ch1 both request continuously -> grants alternate 0,1,0,1; neither channel is granted twice in succession.
REQ-038 ch0 read in progress, flush[0] pulsed in its second READ cycle -> no done[0], busy low next cycle, ch1 granted on the following cycle.
REQ-039 MEM_CTRL_IO_STALL_EN defined, ch1 write nbytes=1 to 0x30000 with io_buffer_full high 3 cycles -> mem_wr low 3 cycles, then one write of the byte, done[1] one cycle later; undefined -> write issued immediately.
REQ-040 rdy low 2 cycles mid-read -> mem_a and capture index frozen, mem_wr 0, done delayed by exactly 2 cycles, rdata correct.
